// File: rtl/uart_rx_fifo.sv
// UART receiver with internal baud divider, 3-sample majority vote, framing check and receive FIFO.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned CLK_DIV    = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_en,
  input  logic                          din,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned Mid  = CLK_DIV / 2;
  localparam int unsigned Aw   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = 16;
  localparam int unsigned BitW = 4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  state_e                 state_q, state_d;
  logic                   sync_q, rxs_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [1:0]             samp_q, samp_d;
  logic                   decide, maj, push;

  assign decide = (cnt_q == CntW'(Mid + 1));
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  assign busy   = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, perr;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    // The counter free-runs across bit boundaries so consecutive decisions stay CLK_DIV apart.
    cnt_d     = (cnt_q == CntW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    data_d    = data_q;
    samp_d    = samp_q;
    push      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr      = 1'b0;
`endif
    if (cnt_q == CntW'(Mid - 1)) samp_d[0] = rxs_q;
    if (cnt_q == CntW'(Mid))     samp_d[1] = rxs_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_en && !rxs_q) state_d = StStart;
      end
      StStart: begin
        if (decide) begin
          bit_d   = '0;
          state_d = maj ? StIdle : StData;
        end
      end
      StData: begin
        if (decide) begin
          data_d = {maj, data_q[DATA_BITS-1:1]};
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (decide) begin
          par_bad_d = ((^data_q) ^ maj) != PARITY_ODD[0];
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (decide) begin
          if (!maj) begin
            frame_err = 1'b1;
            state_d   = StBreak;
          end else if (bit_q == BitW'(STOP_BITS - 1)) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) perr = 1'b1;
            else           push = 1'b1;
`else
            push = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      samp_q    <= 2'b11;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync_q    <= din;
      rxs_q     <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      samp_q    <= samp_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [Aw-1:0]        wptr_q, rptr_q;
  logic [Aw:0]          count_q, count_d;
  logic                 full, pop, push_ok;

  assign full       = (count_q == (Aw + 1)'(FIFO_DEPTH));
  assign dout_valid = (count_q != '0);
  assign pop        = dout_valid & dout_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok    = push & (~full | pop);
  assign overrun    = push & full & ~pop;
  assign dout       = mem_q[rptr_q];
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_q;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected words queued at frame issue, monitor pops on output.
module tb_uart_rx_fifo;
  localparam int unsigned ClkDiv    = 16;
  localparam int unsigned DataBits  = 8;
  localparam int unsigned StopBits  = 1;
  localparam int unsigned Depth     = 4;
  localparam int unsigned ParityOdd = 0;

  logic                  clk = 1'b0, rst = 1'b0, rx_en = 1'b1, din = 1'b1, dout_ready = 1'b0;
  logic [DataBits-1:0]   dout;
  logic                  dout_valid, frame_err, parity_err, overrun, busy;
  logic [$clog2(Depth):0] fifo_count;

  uart_rx_fifo #(
    .CLK_DIV(ClkDiv), .DATA_BITS(DataBits), .STOP_BITS(StopBits),
    .FIFO_DEPTH(Depth), .PARITY_ODD(ParityOdd)
  ) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .din(din), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DataBits-1:0] exp_q [$];
  logic [DataBits-1:0] exp_word;
  int exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
  int seen_ferr = 0, seen_perr = 0, seen_ovr = 0, seen_words = 0;
  bit rand_ready = 1'b0, ready_force = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: counts error pulses and checks each consumed word against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err)  seen_ferr++;
      if (parity_err) seen_perr++;
      if (overrun)    seen_ovr++;
      if (dout_valid && dout_ready) begin
        seen_words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %0h, required none", dout);
        end else begin
          exp_word = exp_q.pop_front();
          if (dout !== exp_word) begin
            errors++;
            $display("FAIL word: got %0h, required %0h", dout, exp_word);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference model: decides the fate of a frame from its bits alone.
  task automatic expect_frame(input logic [DataBits-1:0] data, input bit stop_ok, input bit pbit);
    bit par_ok;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = (((^data) ^ pbit) == ParityOdd[0]);
`else
    if (pbit) par_ok = 1'b1;
`endif
    if (!stop_ok)                exp_ferr++;
    else if (!par_ok)            exp_perr++;
    else if (exp_q.size() >= Depth) exp_ovr++;
    else                         exp_q.push_back(data);
  endtask

  task automatic send_frame(input logic [DataBits-1:0] data, input bit stop_val, input bit pbit);
    din = 1'b0;
    cyc(ClkDiv);
    for (int i = 0; i < DataBits; i++) begin
      din = data[i];
      cyc(ClkDiv);
    end
`ifdef UART_RX_PARITY_EN
    din = pbit;
    cyc(ClkDiv);
`else
    if (pbit) din = din;
`endif
    din = stop_val;
    cyc(ClkDiv * StopBits);
    if (stop_val) din = 1'b1;
  endtask

  task automatic good_frame(input logic [DataBits-1:0] data);
    bit pbit;
    pbit = ((^data) ^ ParityOdd[0]);
    expect_frame(data, 1'b1, pbit);
    send_frame(data, 1'b1, pbit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int waited;
    logic [DataBits-1:0] d;
    bit bad, pbit;

    cyc(2);
    check("reset_busy", busy, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_count", fifo_count, 0);
    check("reset_dout", dout, 0);
    rst = 1'b1;
    cyc(5);

    // Exact latency: dout_valid rises 1 cycle after the stop decision (157 cycles after start edge).
    ready_force = 1'b0;
    expect_frame(8'hA5, 1'b1, ((^8'hA5) ^ ParityOdd[0]));
    fork
      send_frame(8'hA5, 1'b1, ((^8'hA5) ^ ParityOdd[0]));
      begin
`ifdef UART_RX_PARITY_EN
        cyc(156 + ClkDiv);
`else
        cyc(156);
`endif
        check("a5_valid_early", dout_valid, 0);
        cyc(1);
        check("a5_valid", dout_valid, 1);
        check("a5_dout", dout, 8'hA5);
        check("a5_count", fifo_count, 1);
      end
    join
    check("a5_no_ferr", seen_ferr, 0);
    ready_force = 1'b1;
    cyc(5);
    check("a5_drained", fifo_count, 0);
    ready_force = 1'b0;

    // Start-bit glitch.
    din = 1'b0;
    cyc(5);
    din = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (busy) busy_cycles++;
    end
    check("glitch_busy_seen", (busy_cycles > 0), 1);
    check("glitch_busy_short", (busy_cycles < 16), 1);
    check("glitch_count", fifo_count, 0);
    check("glitch_ferr", seen_ferr, 0);

    // Framing error followed by held-low line.
    expect_frame(8'h3C, 1'b0, ((^8'h3C) ^ ParityOdd[0]));
    send_frame(8'h3C, 1'b0, ((^8'h3C) ^ ParityOdd[0]));
    cyc(40);
    check("break_busy", busy, 1);
    check("break_count", fifo_count, 0);
    check("break_ferr", seen_ferr, exp_ferr);
    din = 1'b1;
    cyc(6);
    check("break_exit", busy, 0);
    check("break_ferr_once", seen_ferr, exp_ferr);

    // Overrun with consumer stalled.
    for (int i = 1; i <= 5; i++) good_frame(DataBits'(i));
    cyc(20);
    check("ovr_count", fifo_count, Depth);
    check("ovr_pulse", seen_ovr, exp_ovr);
    check("ovr_head", dout, 8'h01);
    ready_force = 1'b1;
    cyc(10);
    check("ovr_drained", fifo_count, 0);
    ready_force = 1'b0;

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    cyc(10);
    check("par_count", fifo_count, 1);
    check("par_err", seen_perr, exp_perr);
    ready_force = 1'b1;
    cyc(5);
    ready_force = 1'b0;
`endif

    // Asynchronous reset mid-frame with a word already buffered.
    good_frame(8'h5A);
    cyc(5);
    din = 1'b0;
    cyc(ClkDiv);
    din = 1'b1;
    cyc(3 * ClkDiv);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_dout", dout, 0);
    check("rst_pulses", {frame_err, parity_err, overrun}, 0);
    exp_q.delete();
    cyc(3);
    rst = 1'b1;
    cyc(5);
    ready_force = 1'b1;
    good_frame(8'h55);
    cyc(10);
    check("post_rst_count", fifo_count, 0);

    // Randomized traffic.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d    = DataBits'($urandom);
      bad  = ($urandom_range(0, 4) == 0);
      pbit = 1'($urandom_range(0, 1));
`ifndef UART_RX_PARITY_EN
      pbit = ((^d) ^ ParityOdd[0]);
`endif
      expect_frame(d, !bad, pbit);
      send_frame(d, !bad, pbit);
      din = 1'b1;
      cyc($urandom_range(3, 20));
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      cyc(1);
      waited++;
    end
    check("drain_timeout", (waited < 500), 1);
    check("final_ferr", seen_ferr, exp_ferr);
    check("final_perr", seen_perr, exp_perr);
    check("final_ovr", seen_ovr, exp_ovr);
    check("final_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
